// File: rtl/axi4lite_master_bridge_if.sv
// Host request/response and AXI4-Lite signal bundle for axi4lite_master_bridge.
// The master modport is the bridge's view; the slave modport is the host plus AXI slave.
interface axi4lite_master_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_wr;
    logic                  req_rd;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_data;
    logic [3:0]            req_strb;
    logic                  busy;
    logic                  rsp_ack;
    logic                  rsp_err;
    logic [31:0]           rsp_data;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport master (
        input  req_wr, req_rd, req_addr, req_data, req_strb,
        output busy, rsp_ack, rsp_err, rsp_data,
        output awvalid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport slave (
        output req_wr, req_rd, req_addr, req_data, req_strb,
        input  busy, rsp_ack, rsp_err, rsp_data,
        input  awvalid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );
endinterface

// File: rtl/axi4lite_master_bridge.sv
// Single-outstanding AXI4-Lite initiator driven by one-cycle host request strobes,
// returning a one-cycle acknowledge with status and read data.
module axi4lite_master_bridge #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    axi4lite_master_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q;
    logic                  rsp_ack_q;
    logic                  rsp_err_q;
    logic [31:0]           rsp_data_q;
    logic                  awvalid_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic                  wvalid_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic                  rready_q;

    // Only resp[1] distinguishes an error; EXOKAY collapses onto OKAY.
    logic unused_resp_lsb;
    assign unused_resp_lsb = bus.bresp[0] ^ bus.rresp[0];

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_q    <= IDLE;
            rsp_ack_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
            awvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            wvalid_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            rready_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_ack_q <= 1'b0;
                    if (bus.req_wr && bus.req_rd) begin
                        state_q    <= DONE;
                        rsp_ack_q  <= 1'b1;
                        rsp_err_q  <= 1'b1;
                        rsp_data_q <= '0;
                    end else if (bus.req_wr) begin
                        state_q   <= WRITE;
                        awaddr_q  <= bus.req_addr;
                        wdata_q   <= bus.req_data;
                        wstrb_q   <= bus.req_strb;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        bready_q  <= 1'b1;
                    end else if (bus.req_rd) begin
                        state_q   <= READ;
                        araddr_q  <= bus.req_addr;
                        arvalid_q <= 1'b1;
                        rready_q  <= 1'b1;
                    end
                end

                // A B response may legally arrive before AW/W finish; it ends the write.
                WRITE: begin
                    if (awvalid_q && bus.awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && bus.wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (bus.bvalid && bready_q) begin
                        state_q    <= DONE;
                        rsp_ack_q  <= 1'b1;
                        rsp_err_q  <= bus.bresp[1];
                        rsp_data_q <= '0;
                        awvalid_q  <= 1'b0;
                        wvalid_q   <= 1'b0;
                        bready_q   <= 1'b0;
                    end
                end

                READ: begin
                    if (arvalid_q && bus.arready) begin
                        arvalid_q <= 1'b0;
                    end
                    if (bus.rvalid && rready_q) begin
                        state_q    <= DONE;
                        rsp_ack_q  <= 1'b1;
                        rsp_err_q  <= bus.rresp[1];
                        rsp_data_q <= bus.rdata;
                        arvalid_q  <= 1'b0;
                        rready_q   <= 1'b0;
                    end
                end

                DONE: begin
                    state_q   <= IDLE;
                    rsp_ack_q <= 1'b0;
                end

                default: begin
                    state_q   <= IDLE;
                    rsp_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.rsp_ack  = rsp_ack_q;
    assign bus.rsp_err  = rsp_err_q;
    assign bus.rsp_data = rsp_data_q;

    assign bus.awvalid  = awvalid_q;
    assign bus.awaddr   = awaddr_q;
    assign bus.awprot   = 3'b000;
    assign bus.wvalid   = wvalid_q;
    assign bus.wdata    = wdata_q;
    assign bus.wstrb    = wstrb_q;
    assign bus.bready   = bready_q;
    assign bus.arvalid  = arvalid_q;
    assign bus.araddr   = araddr_q;
    assign bus.arprot   = 3'b000;
    assign bus.rready   = rready_q;

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// Directed bench for axi4lite_master_bridge: the bench plays host and AXI slave cycle by cycle.
// Inputs change and outputs are checked 1 ns after each rising edge.
module tb_axi4lite_master_bridge;

    logic aclk;
    logic areset_n;
    int   checks;
    int   errors;

    axi4lite_master_bridge_if #(.ADDR_WIDTH(32)) bus ();

    axi4lite_master_bridge #(.ADDR_WIDTH(32)) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .bus      (bus.master)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Host side: one set of request fields per call, cleared by calling with zeros.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb);
        bus.req_wr   = wr;
        bus.req_rd   = rd;
        bus.req_addr = addr;
        bus.req_data = data;
        bus.req_strb = strb;
    endtask

    task automatic driveSlave(input logic awr, input logic wr, input logic bv, input logic [1:0] br,
                              input logic arr, input logic rv, input logic [31:0] rd,
                              input logic [1:0] rr);
        bus.awready = awr;
        bus.wready  = wr;
        bus.bvalid  = bv;
        bus.bresp   = br;
        bus.arready = arr;
        bus.rvalid  = rv;
        bus.rdata   = rd;
        bus.rresp   = rr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        areset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        driveSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_busy",     {31'b0, bus.busy},    32'h0);
        checkOutput("rst_ack",      {31'b0, bus.rsp_ack}, 32'h0);
        checkOutput("rst_err",      {31'b0, bus.rsp_err}, 32'h0);
        checkOutput("rst_data",     bus.rsp_data,         32'h0);
        checkOutput("rst_valids",   {27'b0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 32'h0);
        checkOutput("rst_awaddr",   bus.awaddr,           32'h0);
        checkOutput("rst_wdata",    bus.wdata,            32'h0);
        checkOutput("rst_prot",     {26'b0, bus.awprot, bus.arprot}, 32'h0);
        areset_n = 1'b1;
        tick();

        $display("[TB] zero-wait write");
        applyStimulus(1'b1, 1'b0, 32'h4, 32'hA5A5_1234, 4'hF);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("w1_valids",  {29'b0, bus.awvalid, bus.wvalid, bus.bready}, 32'h7);
        checkOutput("w1_awaddr",  bus.awaddr,          32'h4);
        checkOutput("w1_wdata",   bus.wdata,           32'hA5A5_1234);
        checkOutput("w1_wstrb",   {28'b0, bus.wstrb},  32'hF);
        checkOutput("w1_busy",    {31'b0, bus.busy},   32'h1);
        driveSlave(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
        tick();
        checkOutput("w1_hs_done", {29'b0, bus.awvalid, bus.wvalid, bus.bready}, 32'h1);
        checkOutput("w1_no_ack",  {31'b0, bus.rsp_ack}, 32'h0);
        driveSlave(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
        tick();
        driveSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("w1_ack",     {31'b0, bus.rsp_ack}, 32'h1);
        checkOutput("w1_err",     {31'b0, bus.rsp_err}, 32'h0);
        checkOutput("w1_data",    bus.rsp_data,         32'h0);
        checkOutput("w1_bready0", {31'b0, bus.bready},  32'h0);
        tick();
        checkOutput("w1_ack_end", {30'b0, bus.rsp_ack, bus.busy}, 32'h0);

        $display("[TB] write with delayed awready and a dropped request while busy");
        applyStimulus(1'b1, 1'b0, 32'h8, 32'h1122_3344, 4'h3);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("w2_c1_valids", {30'b0, bus.awvalid, bus.wvalid}, 32'h3);
        driveSlave(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
        tick();
        checkOutput("w2_c2_valids", {30'b0, bus.awvalid, bus.wvalid}, 32'h2);
        checkOutput("w2_c2_awaddr", bus.awaddr, 32'h8);
        driveSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
        applyStimulus(1'b1, 1'b0, 32'hC, 32'hFFFF_FFFF, 4'hF);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("w2_c3_awvalid", {31'b0, bus.awvalid}, 32'h1);
        checkOutput("w2_c3_awaddr",  bus.awaddr,           32'h8);
        checkOutput("w2_c3_wdata",   bus.wdata,            32'h1122_3344);
        driveSlave(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
        tick();
        checkOutput("w2_c4_awvalid", {31'b0, bus.awvalid}, 32'h0);
        checkOutput("w2_c4_bready",  {31'b0, bus.bready},  32'h1);
        driveSlave(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 2'b00);
        tick();
        driveSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("w2_ack",        {31'b0, bus.rsp_ack}, 32'h1);
        checkOutput("w2_exokay_err", {31'b0, bus.rsp_err}, 32'h0);
        tick();
        checkOutput("w2_single_ack", {31'b0, bus.rsp_ack}, 32'h0);
        checkOutput("w2_no_new_aw",  {31'b0, bus.awvalid}, 32'h0);
        checkOutput("w2_idle",       {31'b0, bus.busy},    32'h0);

        $display("[TB] read with delayed arready and SLVERR");
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("r1_c1", {28'b0, bus.arvalid, bus.rready, bus.awvalid, bus.busy}, 32'hD);
        checkOutput("r1_araddr", bus.araddr, 32'h0);
        tick();
        checkOutput("r1_c2_arvalid", {31'b0, bus.arvalid}, 32'h1);
        driveSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 2'b00);
        tick();
        checkOutput("r1_c3", {30'b0, bus.arvalid, bus.rready}, 32'h1);
        driveSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b10);
        tick();
        driveSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("r1_ack",  {31'b0, bus.rsp_ack}, 32'h1);
        checkOutput("r1_data", bus.rsp_data,         32'hDEAD_BEEF);
        checkOutput("r1_err",  {31'b0, bus.rsp_err}, 32'h1);
        tick();
        checkOutput("r1_ack_end",   {31'b0, bus.rsp_ack}, 32'h0);
        checkOutput("r1_data_hold", bus.rsp_data,         32'hDEAD_BEEF);

        $display("[TB] simultaneous wr and rd rejected");
        applyStimulus(1'b1, 1'b1, 32'h40, 32'h1234_5678, 4'hF);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("rej_no_valid", {28'b0, bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 32'h0);
        checkOutput("rej_ack",  {30'b0, bus.rsp_ack, bus.rsp_err}, 32'h3);
        checkOutput("rej_data", bus.rsp_data, 32'h0);
        tick();
        checkOutput("rej_end",  {30'b0, bus.rsp_ack, bus.busy}, 32'h0);

        $display("[TB] B response before AW and W handshakes");
        applyStimulus(1'b1, 1'b0, 32'h50, 32'h0000_00AA, 4'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        driveSlave(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 2'b00);
        tick();
        driveSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("bearly_valids", {29'b0, bus.awvalid, bus.wvalid, bus.bready}, 32'h0);
        checkOutput("bearly_ack",    {30'b0, bus.rsp_ack, bus.rsp_err}, 32'h3);
        tick();

        $display("[TB] reset during pending AW");
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0BAD_0BAD, 4'hF);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("mrst_pre", {31'b0, bus.awvalid}, 32'h1);
        areset_n = 1'b0;
        tick();
        checkOutput("mrst_cleared", {27'b0, bus.awvalid, bus.wvalid, bus.bready, bus.busy, bus.rsp_ack}, 32'h0);
        areset_n = 1'b1;
        tick();
        checkOutput("mrst_no_ack", {31'b0, bus.rsp_ack}, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("mrst_rd_ar", {31'b0, bus.arvalid}, 32'h1);
        checkOutput("mrst_rd_addr", bus.araddr, 32'h20);
        driveSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0BAD_F00D, 2'b00);
        tick();
        driveSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("mrst_rd_bus",  {30'b0, bus.arvalid, bus.rready}, 32'h0);
        checkOutput("mrst_rd_ack",  {30'b0, bus.rsp_ack, bus.rsp_err}, 32'h2);
        checkOutput("mrst_rd_data", bus.rsp_data, 32'h0BAD_F00D);
        tick();

        $display("[TB] back-to-back write then read");
        applyStimulus(1'b1, 1'b0, 32'h30, 32'h55AA_55AA, 4'hF);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("b2b_wdata", bus.wdata, 32'h55AA_55AA);
        driveSlave(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
        tick();
        driveSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("b2b_w_ack", {30'b0, bus.rsp_ack, bus.rsp_err}, 32'h2);
        tick();
        checkOutput("b2b_idle", {30'b0, bus.rsp_ack, bus.busy}, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h34, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("b2b_ar", {31'b0, bus.arvalid}, 32'h1);
        checkOutput("b2b_araddr", bus.araddr, 32'h34);
        driveSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'hCAFE_0001, 2'b01);
        tick();
        driveSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("b2b_r_ack",  {30'b0, bus.rsp_ack, bus.rsp_err}, 32'h2);
        checkOutput("b2b_r_data", bus.rsp_data, 32'hCAFE_0001);
        tick();
        checkOutput("b2b_end", {30'b0, bus.rsp_ack, bus.busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4lite_master_bridge.md
Name: axi4lite_master_bridge

Overview:
AXI4-Lite initiator that turns single-cycle requests from a simple local host interface into AXI4-Lite master transactions. It drives the register-bank slaves generated in this codebase, for example from a CPU-less sequencer or test controller. The bridge allows one outstanding transaction at a time. Completion is returned as a one-cycle acknowledge with status and read data.

Parameters:
ADDR_WIDTH, 32, width of req_addr, awaddr and araddr (byte address, passed through unmodified)

Ports:
aclk  in  1  clock; all logic is rising-edge
areset_n  in  1  reset; synchronous, active-low
req_wr  in  1  write request strobe, sampled only when busy=0
req_rd  in  1  read request strobe, sampled only when busy=0
req_addr  in  ADDR_WIDTH  request byte address
req_data  in  32  write data
req_strb  in  4  write byte strobes
busy  out  1  transaction in progress; requests are ignored while high
rsp_ack  out  1  one-cycle completion pulse
rsp_err  out  1  valid with rsp_ack; 1 when resp[1]=1 (SLVERR/DECERR) or on rejected request
rsp_data  out  32  read data, valid with rsp_ack; 0 for writes and rejects
awvalid  out  1
awready  in  1
awaddr  out  ADDR_WIDTH
awprot  out  3  constant 3'b000
wvalid  out  1
wready  in  1
wdata  out  32
wstrb  out  4
bvalid  in  1
bready  out  1
bresp  in  2
arvalid  out  1
arready  in  1
araddr  out  ADDR_WIDTH
arprot  out  3  constant 3'b000
rvalid  in  1
rready  out  1
rdata  in  32
rresp  in  2

Behaviour:
- Reset (areset_n=0 at a rising edge): state=IDLE. busy, rsp_ack, rsp_err, awvalid, wvalid, bready, arvalid and rready are 0. rsp_data, awaddr, araddr, wdata and wstrb are 0.
- FSM states: IDLE, WRITE, READ, DONE. busy = (state != IDLE), decoded from the registered state.
- IDLE, req_wr=1, req_rd=0 at edge N: latch addr, data and strb. Go to WRITE. awvalid, wvalid and bready are 1 from cycle N+1.
- IDLE, req_rd=1, req_wr=0 at edge N: latch addr. Go to READ. arvalid and rready are 1 from cycle N+1.
- IDLE, req_wr=1 and req_rd=1 together: rejected. No AXI activity. Go to DONE with rsp_err=1 and rsp_data=0.
- WRITE: AW and W are independent.
  - awvalid clears on the edge where awvalid&awready=1.
  - wvalid clears on the edge where wvalid&wready=1.
  - Both handshakes in the same cycle are legal.
  - Once a valid is asserted it stays high, with stable payload, until its handshake.
  - bready stays 1 throughout WRITE.
  - A B handshake (bvalid&bready) is honoured even if it arrives before both AW and W have completed. On that handshake: capture rsp_err=bresp[1], clear any remaining valids, go to DONE.
- READ: arvalid clears on the AR handshake. rready stays 1 throughout READ. An R handshake is honoured even in the same cycle as the AR handshake. On the R handshake: capture rsp_data=rdata and rsp_err=rresp[1], go to DONE.
- DONE: rsp_ack=1 for exactly one cycle, then IDLE. rsp_data and rsp_err hold until the next rsp_ack.
- Latency with zero-wait slave: a request at edge N gives handshakes in cycle N+1, the response handshake in cycle N+1 or later, and rsp_ack in the cycle after the response handshake. The earliest next request is accepted at the edge after the rsp_ack cycle.
- Requests seen while busy=1 are dropped silently; they are not queued.
- Reset mid-transaction: all valids and readies drop at that edge and the FSM returns to IDLE. The in-flight transaction is abandoned and no rsp_ack is issued.
- bresp[0] and rresp[0] do not affect rsp_err (EXOKAY is treated as OKAY).

Test Plan:
- Zero-wait write, addr 0x4, data 0xA5A5_1234, strb 0xF -> awaddr=0x4 and wdata=0xA5A5_1234 on the bus in cycle N+1; bvalid returned in N+2 -> rsp_ack=1 in N+3 with rsp_err=0 and rsp_data=0.
- Write, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle while awvalid holds 3 cycles with stable awaddr; single rsp_ack after B.
- Read addr 0x0, arready delayed 2 cycles, rdata=0xDEAD_BEEF with rresp=2'b10 -> rsp_ack once, rsp_data=0xDEAD_BEEF, rsp_err=1.
- req_wr and req_rd in the same cycle -> no valid asserted; rsp_ack after 1 cycle with rsp_err=1 and rsp_data=0. Also: req_wr pulsed while busy=1 -> ignored, exactly one AW transaction seen.
- areset_n=0 while awvalid=1 waiting for awready -> next cycle awvalid=wvalid=bready=busy=0, no rsp_ack; a new read issued afterwards completes normally.
- Back-to-back write then read, zero-wait slave -> second request accepted the cycle after the first rsp_ack; both complete with correct data.
